stopwatch_ctrl: RTL
===================

Name: stopwatch_ctrl

Overview:
Mode controller for the MM:SS stopwatch datapath. It takes debounced/one-pulsed start_stop and lap_rst_n button events and sequences the BCD counters and the lap display registers. It produces the counter increment strobe, the synchronous clear and the lap-freeze control, and replaces the ad-hoc button FSMs and long-push detector. It sits between the debounce/one_pulse stage and the counter/load_reg/scan datapath, in the 100 Hz domain.

Parameters:
TICK_DIV, 100, clk cycles per counted second (prescaler modulus), >=2
LONG_CYCLES, 100, consecutive cycles lap_level must stay high to issue a clear, >=2
CNT_W, 7, width of the prescaler and hold counters; must hold max(TICK_DIV, LONG_CYCLES)

Ports:
clk  input  1  system clock (100 Hz domain); all state on rising edge
rst_n  input  1  asynchronous active-low reset
start_pulse  input  1  one-cycle pulse, start_stop pressed
lap_pulse  input  1  one-cycle pulse, lap_rst_n pressed (press edge)
lap_level  input  1  debounced level of lap_rst_n, 1 = held
cnt_inc  output  1  one-cycle strobe: add 1 s to the seconds counter
cnt_clr  output  1  one-cycle synchronous clear for counters and lap registers
lap_hold  output  1  1 = lap registers keep their value; 0 = load live count each cycle
running  output  1  1 in RUN or LAP
state  output  3  current state encoding, for debug/LED

Behaviour:
- Reset (async, rst_n=0): state=IDLE, prescaler=0, hold counter=0, cnt_inc=0, cnt_clr=0, lap_hold=0, running=0. Outputs are registered, so the first change appears 1 cycle after the triggering input.
- States: IDLE(0), RUN(1), STOP(2), LAP(3), LAP_STOP(4). running=1 in RUN/LAP. lap_hold=1 in LAP/LAP_STOP.
- Transitions on start_pulse: IDLE->RUN, RUN->STOP, STOP->RUN, LAP->LAP_STOP, LAP_STOP->LAP.
- Transitions on lap_pulse, only when start_pulse=0: RUN->LAP, LAP->RUN, LAP_STOP->STOP. Ignored in IDLE and STOP.
- Priority: start_pulse wins over lap_pulse in the same cycle; the lap_pulse is dropped, not queued.
- Hold counter:
  - Clears while lap_level=0.
  - Increments while lap_level=1; saturates at LONG_CYCLES.
  - A clear event is the cycle the counter goes LONG_CYCLES-1 -> LONG_CYCLES. Exactly one per hold; no repeat until lap_level drops.
- Clear event:
  - In IDLE, STOP or LAP_STOP: cnt_clr=1 for one cycle, state->IDLE, prescaler=0. The clear event overrides a coincident start_pulse.
  - In RUN or LAP: ignored. The counter stays saturated, so a later move to STOP during the same hold does not clear.
- Prescaler: counts 0..TICK_DIV-1 only while running=1 and holds its value otherwise, so a pause/resume loses no partial second.
  - cnt_inc=1 for one cycle on the wrap TICK_DIV-1 -> 0.
  - First cnt_inc comes TICK_DIV cycles after entering RUN from IDLE.
  - Reset to 0 on a clear event and on async reset.
- cnt_inc and cnt_clr are never high in the same cycle.
- Reset mid-operation: all state returns to reset values immediately. A button held through reset deassertion counts from 0 on the first active edge.

Decomposition:
- stopwatch_pkg: state encoding localparams (ST_IDLE..ST_LAP_STOP) and the default TICK_DIV/LONG_CYCLES constants, shared with the bench.
- One sub-module, sat_counter: a saturating hold counter with clear-on-low and a single-cycle "reached" pulse, instantiated once for lap_level.
- The prescaler and FSM stay inline.

Test Plan:
All scenarios use TICK_DIV=4, LONG_CYCLES=6.
1. Reset, then start_pulse at cycle 0 -> running=1 at cycle 1; cnt_inc high at cycles 4, 8, 12; state=1.
2. Run 6 cycles, start_pulse (STOP), wait 10, start_pulse again -> prescaler resumes; next cnt_inc exactly 2 running cycles after resume; no cnt_inc while stopped.
3. In RUN, lap_pulse -> lap_hold=1 next cycle and cnt_inc continues. lap_pulse again -> lap_hold=0. Then start_pulse+lap_pulse in the same cycle from LAP -> LAP_STOP with lap_hold=1.
4. In STOP, hold lap_level 6 cycles -> cnt_clr single pulse on the 6th cycle, state=IDLE next cycle. Keep holding 20 more cycles -> no second cnt_clr.
5. In RUN, hold lap_level 8 cycles -> no cnt_clr. Then start_pulse while still held -> STOP, no cnt_clr. Release and hold 6 cycles -> cnt_clr.
6. In STOP, set the clear event cycle coincident with start_pulse -> cnt_clr=1 and state=IDLE, not RUN. Then assert rst_n=0 mid-RUN -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared constants for the MM:SS stopwatch mode controller: state encoding
// and default prescaler / long-push lengths.
package stopwatch_pkg;

    localparam int TICK_DIV_DEF    = 100;
    localparam int LONG_CYCLES_DEF = 100;
    localparam int CNT_W_DEF       = 7;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_STOP     = 3'd2,
        ST_LAP      = 3'd3,
        ST_LAP_STOP = 3'd4
    } state_e;

    function automatic logic is_running(input state_e s);
        return (s == ST_RUN) || (s == ST_LAP);
    endfunction

    function automatic logic is_lap(input state_e s);
        return (s == ST_LAP) || (s == ST_LAP_STOP);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_sat_counter.sv
// Saturating hold counter: clears while level is low, counts while high and
// pulses `reached` on the single cycle it steps MAX-1 -> MAX.
module sat_counter #(
    parameter int MAX = 100,
    parameter int W   = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic reached
);

    logic [W-1:0] count;

    assign reached = level && (count == W'(MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (!level)
            count <= '0;
        else if (count != W'(MAX))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: button-driven FSM, seconds prescaler and
// long-push clear, producing registered counter/lap-register controls.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV    = TICK_DIV_DEF,
    parameter int LONG_CYCLES = LONG_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_pulse,
    input  logic       lap_pulse,
    input  logic       lap_level,
    output logic       cnt_inc,
    output logic       cnt_clr,
    output logic       lap_hold,
    output logic       running,
    output logic [2:0] state
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] pre_q;
    logic             long_push;
    logic             do_clr;
    logic             run_d;
    logic             wrap;

    sat_counter #(
        .MAX (LONG_CYCLES),
        .W   (CNT_W)
    ) u_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .level   (lap_level),
        .reached (long_push)
    );

    always_comb begin
        state_d = state_q;
        do_clr  = 1'b0;
        unique case (state_q)
            ST_IDLE:     if (start_pulse) state_d = ST_RUN;
            ST_RUN:      if (start_pulse) state_d = ST_STOP;
                         else if (lap_pulse) state_d = ST_LAP;
            ST_STOP:     if (start_pulse) state_d = ST_RUN;
            ST_LAP:      if (start_pulse) state_d = ST_LAP_STOP;
                         else if (lap_pulse) state_d = ST_RUN;
            ST_LAP_STOP: if (start_pulse) state_d = ST_LAP;
                         else if (lap_pulse) state_d = ST_STOP;
            default:     state_d = ST_IDLE;
        endcase
        // A long push only clears when not counting; it beats any coincident start.
        if (long_push && !is_running(state_q)) begin
            do_clr  = 1'b1;
            state_d = ST_IDLE;
        end
    end

    // Prescaler advances on edges that land in a running state, so the
    // first strobe shows TICK_DIV cycles after the start press.
    assign run_d = is_running(state_d);
    assign wrap  = run_d && (pre_q == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pre_q   <= '0;
            cnt_inc <= 1'b0;
            cnt_clr <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_inc <= wrap;
            cnt_clr <= do_clr;
            if (do_clr)
                pre_q <= '0;
            else if (run_d)
                pre_q <= wrap ? '0 : pre_q + 1'b1;
        end
    end

    assign running  = is_running(state_q);
    assign lap_hold = is_lap(state_q);
    assign state    = state_q;

endmodule
